// File: rtl/fetch_seq_ctrl_if.sv
// fetch_seq_ctrl_if: bundle of EX, branch-predictor and PC-register signals around the fetch sequencer.
// master is the sequencer side; slave is the surrounding pipeline.
interface fetch_seq_ctrl_if #(parameter int XLEN = 5);
   logic [XLEN-1:0] F_pc, EX_alt_pc, BP_target_pc, pc_alt_pc, pc_next;
   logic            EX_taken, BP_hit, stall_D, trap_req, halt_req, resume;
   logic            pc_taken, pc_hold, F_valid, flush_FD, flush_DE, trap_ack, halted;
   logic [7:0]      redirect_cnt;
   modport master (
      input  F_pc, EX_taken, EX_alt_pc, BP_hit, BP_target_pc, stall_D, trap_req, halt_req, resume,
      output pc_taken, pc_alt_pc, pc_hold, pc_next, F_valid, flush_FD, flush_DE, trap_ack, halted,
             redirect_cnt
   );
   modport slave (
      output F_pc, EX_taken, EX_alt_pc, BP_hit, BP_target_pc, stall_D, trap_req, halt_req, resume,
      input  pc_taken, pc_alt_pc, pc_hold, pc_next, F_valid, flush_FD, flush_DE, trap_ack, halted,
             redirect_cnt
   );
endinterface

// File: rtl/fetch_seq_ctrl.sv
// fetch_seq_ctrl: drives PC-register controls, arbitrating EX redirect > pending trap > predictor,
// with a BOOT/RUN/FLUSH/HALT sequencer and a saturating redirect counter.
module fetch_seq_ctrl #(
   parameter int              XLEN     = 5,
   parameter logic [XLEN-1:0] TRAP_VEC = XLEN'(28)
) (
   input logic              clk,
   input logic              rst,
   fetch_seq_ctrl_if.master fs_i
);
   typedef enum logic [1:0] {BOOT, RUN, FLUSH, HALT} state_t;
   state_t     state_q, state_d;
   logic       trap_pend_q, trap_pend_d;
   logic [7:0] cnt_q, cnt_d;
   logic       active, ex_redir, trap_redir, redir;
   assign active     = state_q != BOOT;
   assign ex_redir   = fs_i.EX_taken & active;
   // EX is older than the trap, so a pending trap waits for a cycle without EX_taken
   assign trap_redir = trap_pend_q & ~fs_i.EX_taken & active;
   assign redir      = ex_redir | trap_redir;
   assign fs_i.pc_taken     = redir;
   assign fs_i.pc_alt_pc    = ex_redir ? fs_i.EX_alt_pc : trap_redir ? TRAP_VEC : '0;
   assign fs_i.pc_next      = fs_i.BP_hit ? fs_i.BP_target_pc : fs_i.F_pc + XLEN'(1);
   assign fs_i.pc_hold      = ~redir & ((state_q != RUN) | fs_i.stall_D);
   assign fs_i.F_valid      = (state_q == RUN) & ~fs_i.stall_D;
   assign fs_i.flush_FD     = redir;
   assign fs_i.flush_DE     = redir;
   assign fs_i.trap_ack     = trap_redir;
   assign fs_i.halted       = state_q == HALT;
   assign fs_i.redirect_cnt = cnt_q;
   always_comb begin
      state_d     = state_q;
      trap_pend_d = fs_i.trap_req | (trap_pend_q & ~trap_redir);
      cnt_d       = (redir && cnt_q != 8'hFF) ? cnt_q + 8'd1 : cnt_q;
      if (redir)
         state_d = FLUSH;
      else
         case (state_q)
            BOOT:       state_d = RUN;
            RUN, FLUSH: state_d = fs_i.halt_req ? HALT : RUN;
            HALT:       state_d = fs_i.resume ? RUN : HALT;
            default:    state_d = BOOT;
         endcase
   end
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= BOOT;
         trap_pend_q <= 1'b0;
         cnt_q       <= 8'd0;
      end else begin
         state_q     <= state_d;
         trap_pend_q <= trap_pend_d;
         cnt_q       <= cnt_d;
      end
   end
endmodule

// File: tb/tb_fetch_seq_ctrl.sv
// tb_fetch_seq_ctrl: directed scenarios plus random traffic against a mode-level reference model;
// the bench also plays the PC register, fed from the model's expected controls.
module tb_fetch_seq_ctrl;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int   vec = 0, err = 0;
   fetch_seq_ctrl_if #(.XLEN(5)) bus ();
   fetch_seq_ctrl #(.XLEN(5), .TRAP_VEC(5'd28)) dut (.clk(clk), .rst(rst), .fs_i(bus));
   always #5 clk = ~clk;

   string m_mode;
   bit    m_pend;
   int    m_cnt;
   bit    e_taken, e_hold, e_valid, e_ack, e_halted;
   int    e_alt, e_next;

   task automatic clear();
      bus.EX_taken = 0; bus.EX_alt_pc = 0; bus.BP_hit = 0; bus.BP_target_pc = 0;
      bus.stall_D = 0; bus.trap_req = 0; bus.halt_req = 0; bus.resume = 0;
   endtask

   task automatic model_reset();
      m_mode = "BOOT"; m_pend = 0; m_cnt = 0;
   endtask

   task automatic settle();
      bit act, ex, tr;
      @(negedge clk);
      act = m_mode != "BOOT";
      ex  = bus.EX_taken && act;
      tr  = m_pend && !bus.EX_taken && act;
      e_taken  = ex || tr;
      e_alt    = ex ? int'(bus.EX_alt_pc) : tr ? 28 : 0;
      e_next   = bus.BP_hit ? int'(bus.BP_target_pc) : (int'(bus.F_pc) + 1) % 32;
      e_hold   = e_taken ? 1'b0 : (m_mode == "RUN") ? bus.stall_D : 1'b1;
      e_valid  = m_mode == "RUN" && !bus.stall_D;
      e_ack    = tr;
      e_halted = m_mode == "HALT";
   endtask

   task automatic tick();
      string nm;
      int    npc, ncnt;
      bit    npend;
      nm = e_taken ? "FLUSH" : m_mode == "BOOT" ? "RUN" :
           m_mode == "HALT" ? (bus.resume ? "RUN" : "HALT") : (bus.halt_req ? "HALT" : "RUN");
      npc   = e_taken ? e_alt : e_hold ? int'(bus.F_pc) : e_next;
      npend = bus.trap_req || (m_pend && !e_ack);
      ncnt  = m_cnt + int'(e_taken) > 255 ? 255 : m_cnt + int'(e_taken);
      @(posedge clk);
      m_mode = nm; m_pend = npend; m_cnt = ncnt;
      #1 bus.F_pc = 5'(npc);
   endtask

   task automatic test_reset();
      clear(); bus.F_pc = 0; rst = 1; model_reset();
      #2;
      vec++; if ({bus.pc_taken, bus.pc_hold, bus.F_valid, bus.flush_FD, bus.flush_DE, bus.trap_ack, bus.halted} !== 7'b0100000)
         begin err++; $display("FAIL reset_ctl got=%b exp=0100000", {bus.pc_taken, bus.pc_hold, bus.F_valid, bus.flush_FD, bus.flush_DE, bus.trap_ack, bus.halted}); end
      vec++; if (bus.redirect_cnt !== 8'd0 || bus.pc_alt_pc !== 5'd0)
         begin err++; $display("FAIL reset_cnt_alt got=%0d/%0d exp=0/0", bus.redirect_cnt, bus.pc_alt_pc); end
      @(posedge clk); #1 rst = 0;
      settle();
      vec++; if (bus.F_valid !== 1'b0 || bus.pc_hold !== 1'b1 || bus.pc_next !== 5'd1)
         begin err++; $display("FAIL boot valid/hold/next got=%b/%b/%0d exp=0/1/1", bus.F_valid, bus.pc_hold, bus.pc_next); end
      tick();
      for (int i = 1; i <= 3; i++) begin
         settle();
         vec++; if (bus.F_valid !== 1'b1 || bus.pc_next !== 5'(i))
            begin err++; $display("FAIL seq_fetch[%0d] valid/next got=%b/%0d exp=1/%0d", i, bus.F_valid, bus.pc_next, i); end
         tick();
      end
      bus.F_pc = 5'd31;
      settle();
      vec++; if (bus.pc_next !== 5'd0)
         begin err++; $display("FAIL pc_wrap got=%0d exp=0", bus.pc_next); end
      tick();
   endtask

   task automatic test_ex_redirect();
      clear(); bus.stall_D = 1; bus.EX_taken = 1; bus.EX_alt_pc = 9;
      settle();
      vec++; if ({bus.pc_taken, bus.pc_hold, bus.flush_FD, bus.flush_DE} !== 4'b1011 || bus.pc_alt_pc !== 5'd9)
         begin err++; $display("FAIL ex_redir taken/hold/fFD/fDE=%b alt=%0d exp=1011 alt=9", {bus.pc_taken, bus.pc_hold, bus.flush_FD, bus.flush_DE}, bus.pc_alt_pc); end
      tick(); clear();
      settle();
      vec++; if (bus.F_valid !== 1'b0 || bus.redirect_cnt !== 8'd1)
         begin err++; $display("FAIL ex_flush valid/cnt got=%b/%0d exp=0/1", bus.F_valid, bus.redirect_cnt); end
      tick();
      settle();
      vec++; if (bus.F_valid !== 1'b1)
         begin err++; $display("FAIL ex_resume valid got=%b exp=1", bus.F_valid); end
      tick();
   endtask

   task automatic test_trap_ex();
      int c0;
      c0 = m_cnt;
      clear(); bus.trap_req = 1; bus.EX_taken = 1; bus.EX_alt_pc = 4;
      settle();
      vec++; if (bus.pc_alt_pc !== 5'd4 || bus.trap_ack !== 1'b0 || bus.pc_taken !== 1'b1)
         begin err++; $display("FAIL trap_ex_first alt/ack/taken got=%0d/%b/%b exp=4/0/1", bus.pc_alt_pc, bus.trap_ack, bus.pc_taken); end
      tick(); clear();
      settle();
      vec++; if (bus.pc_alt_pc !== 5'd28 || bus.trap_ack !== 1'b1 || bus.pc_taken !== 1'b1 || bus.flush_DE !== 1'b1)
         begin err++; $display("FAIL trap_second alt/ack/taken/fl got=%0d/%b/%b/%b exp=28/1/1/1", bus.pc_alt_pc, bus.trap_ack, bus.pc_taken, bus.flush_DE); end
      tick();
      settle();
      vec++; if (bus.redirect_cnt !== 8'(c0 + 2) || bus.F_valid !== 1'b0 || bus.trap_ack !== 1'b0)
         begin err++; $display("FAIL trap_after cnt/valid/ack got=%0d/%b/%b exp=%0d/0/0", bus.redirect_cnt, bus.F_valid, bus.trap_ack, c0 + 2); end
      tick();
   endtask

   task automatic test_predictor();
      clear(); bus.BP_hit = 1; bus.BP_target_pc = 17;
      settle();
      vec++; if (bus.pc_next !== 5'd17 || bus.pc_taken !== 1'b0 || bus.flush_FD !== 1'b0 || bus.flush_DE !== 1'b0 || bus.F_valid !== 1'b1)
         begin err++; $display("FAIL bp_hit next/taken/fFD/fDE/valid got=%0d/%b/%b/%b/%b exp=17/0/0/0/1", bus.pc_next, bus.pc_taken, bus.flush_FD, bus.flush_DE, bus.F_valid); end
      tick();
   endtask

   task automatic test_halt();
      clear(); bus.halt_req = 1;
      settle(); tick(); clear();
      settle();
      vec++; if ({bus.halted, bus.pc_hold, bus.F_valid} !== 3'b110)
         begin err++; $display("FAIL halt_enter halted/hold/valid got=%b exp=110", {bus.halted, bus.pc_hold, bus.F_valid}); end
      tick();
      bus.halt_req = 1; bus.resume = 1;
      settle(); tick(); clear();
      settle();
      vec++; if (bus.halted !== 1'b0 || bus.F_valid !== 1'b1)
         begin err++; $display("FAIL halt_resume halted/valid got=%b/%b exp=0/1", bus.halted, bus.F_valid); end
      bus.halt_req = 1;
      tick(); clear(); bus.trap_req = 1;
      settle();
      vec++; if (bus.halted !== 1'b1 || bus.pc_taken !== 1'b0)
         begin err++; $display("FAIL halt_trap_capture halted/taken got=%b/%b exp=1/0", bus.halted, bus.pc_taken); end
      tick(); clear();
      settle();
      vec++; if (bus.pc_taken !== 1'b1 || bus.pc_alt_pc !== 5'd28 || bus.trap_ack !== 1'b1 || bus.pc_hold !== 1'b0)
         begin err++; $display("FAIL halt_trap taken/alt/ack/hold got=%b/%0d/%b/%b exp=1/28/1/0", bus.pc_taken, bus.pc_alt_pc, bus.trap_ack, bus.pc_hold); end
      tick();
      settle();
      vec++; if (bus.halted !== 1'b0 || bus.F_valid !== 1'b0)
         begin err++; $display("FAIL halt_trap_flush halted/valid got=%b/%b exp=0/0", bus.halted, bus.F_valid); end
      tick();
   endtask

   task automatic test_saturate_and_reset();
      clear(); bus.EX_taken = 1;
      for (int i = 0; i < 300; i++) begin
         bus.EX_alt_pc = 5'($urandom);
         settle(); tick();
      end
      clear();
      settle();
      vec++; if (bus.redirect_cnt !== 8'd255)
         begin err++; $display("FAIL cnt_saturate got=%0d exp=255", bus.redirect_cnt); end
      bus.EX_taken = 1; bus.trap_req = 1;
      tick(); clear();
      #2 rst = 1; model_reset();
      #1;
      vec++; if (bus.redirect_cnt !== 8'd0 || bus.pc_hold !== 1'b1 || bus.pc_taken !== 1'b0 || bus.trap_ack !== 1'b0)
         begin err++; $display("FAIL midflush_reset cnt/hold/taken/ack got=%0d/%b/%b/%b exp=0/1/0/0", bus.redirect_cnt, bus.pc_hold, bus.pc_taken, bus.trap_ack); end
      @(posedge clk); #1 rst = 0;
      settle();
      vec++; if (bus.F_valid !== 1'b0 || bus.trap_ack !== 1'b0)
         begin err++; $display("FAIL post_reset_boot valid/ack got=%b/%b exp=0/0", bus.F_valid, bus.trap_ack); end
      tick();
      settle();
      vec++; if (bus.F_valid !== 1'b1 || bus.trap_ack !== 1'b0 || bus.pc_taken !== 1'b0)
         begin err++; $display("FAIL post_reset_run valid/ack/taken got=%b/%b/%b exp=1/0/0", bus.F_valid, bus.trap_ack, bus.pc_taken); end
      tick();
   endtask

   task automatic test_random();
      logic [24:0] got, exp;
      for (int i = 0; i < 500; i++) begin
         bus.EX_taken     = ($urandom % 6) == 0;
         bus.EX_alt_pc    = 5'($urandom);
         bus.BP_hit       = ($urandom % 3) == 0;
         bus.BP_target_pc = 5'($urandom);
         bus.stall_D      = ($urandom % 4) == 0;
         bus.trap_req     = ($urandom % 10) == 0;
         bus.halt_req     = ($urandom % 8) == 0;
         bus.resume       = ($urandom % 3) == 0;
         settle();
         got = {bus.pc_taken, bus.pc_alt_pc, bus.pc_hold, bus.pc_next, bus.F_valid, bus.flush_FD,
                bus.flush_DE, bus.trap_ack, bus.halted, bus.redirect_cnt};
         exp = {e_taken, 5'(e_alt), e_hold, 5'(e_next), e_valid, e_taken, e_taken, e_ack, e_halted, 8'(m_cnt)};
         vec++; if (got !== exp)
            begin err++; $display("FAIL random[%0d] mode=%s got=%h exp=%h", i, m_mode, got, exp); end
         tick();
      end
      clear();
   endtask

   initial begin
      test_reset();
      test_ex_redirect();
      test_trap_ex();
      test_predictor();
      test_halt();
      test_saturate_and_reset();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vec, err);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog expired");
      $fatal(1);
   end
endmodule
